mac_seq_ctrl: RTL and testbench

- Sequencer for the 16-lane signed MAC datapath (mac_16in). Accepts a dot-product as a stream of 16-lane operand chunks.
- Issues each chunk to the MAC in the MAC's sample phase and accumulates the MAC's per-chunk partial sums into a wide accumulator.
- Returns one result per vector on a valid/ready output.
- Owns the MAC's reset so that the MAC's internal load/add alternation stays phase-locked to the controller.

---
 rtl/mac_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: streams 16-lane operand chunks into the external MAC in its
// sample phase and sums the MAC's per-chunk partial sums into one result.
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   in_valid/in_ready chunk handshake; in_last marks the final chunk
//   in_a, in_b        lane operands, passed through to mac_a/mac_b
//   mac_reset         active-high synchronous reset driven to the MAC
//   mac_out           MAC partial sum for the previously sampled chunk
//   out_valid/ready   result handshake; out_data/out_cnt/out_err held in OUT
//   busy              controller not idle
module mac_seq_ctrl #(
    parameter int bw         = 8,
    parameter int pr         = 16,
    parameter int bw_psum    = 2*bw+4,
    parameter int max_chunks = 16,
    parameter int cw         = 4,
    parameter int aw         = bw_psum+cw
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [pr*bw-1:0]   in_a,
    input  logic [pr*bw-1:0]   in_b,
    output logic               mac_reset,
    output logic [pr*bw-1:0]   mac_a,
    output logic [pr*bw-1:0]   mac_b,
    input  logic [bw_psum-1:0] mac_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [aw-1:0]      out_data,
    output logic [cw:0]        out_cnt,
    output logic               out_err,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ACC, WAIT, OUT} state_t;

    localparam int ew = aw - bw_psum;
    localparam logic [cw:0] one  = (cw+1)'(1);
    localparam logic [cw:0] maxc = (cw+1)'(max_chunks);

    state_t        state;
    logic          ph;
    logic [aw-1:0] acc;
    logic [cw:0]   cnt;
    logic [cw:0]   icnt;
    logic          p1, p1_last, p1_err;
    logic          p2, p2_last, p2_err;

    logic          accept;
    logic          closing;
    logic [cw:0]   nxt_icnt;
    logic [aw-1:0] psum_ext;

    assign mac_a = in_a;
    assign mac_b = in_b;

    // ph==0 is the MAC's sample edge, so chunks are only taken then
    assign in_ready = !mac_reset && !ph &&
                      (state == IDLE || state == ACC);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    // issue-side count: the accumulated count lags by two edges
    assign nxt_icnt = (state == IDLE) ? one : icnt + one;
    assign closing  = in_last || (nxt_icnt == maxc);
    assign psum_ext = {{ew{mac_out[bw_psum-1]}}, mac_out};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mac_reset <= 1'b1;
            ph        <= 1'b0;
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            icnt      <= '0;
            p1        <= 1'b0;
            p1_last   <= 1'b0;
            p1_err    <= 1'b0;
            p2        <= 1'b0;
            p2_last   <= 1'b0;
            p2_err    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
            out_err   <= 1'b0;
        end else begin
            // ph starts toggling on the same edge the MAC leaves reset
            if (mac_reset)
                mac_reset <= 1'b0;
            else
                ph <= ~ph;

            p1      <= accept;
            p1_last <= accept && closing;
            p1_err  <= accept && closing && !in_last;
            p2      <= p1;
            p2_last <= p1_last;
            p2_err  <= p1_err;

            if (accept)
                icnt <= nxt_icnt;

            if (p2 && !p2_last) begin
                acc <= acc + psum_ext;
                cnt <= cnt + one;
            end

            unique case (state)
                IDLE: begin
                    if (accept)
                        state <= closing ? WAIT : ACC;
                end
                ACC: begin
                    if (accept && closing)
                        state <= WAIT;
                end
                WAIT: begin
                    if (p2 && p2_last) begin
                        out_data  <= acc + psum_ext;
                        out_cnt   <= cnt + one;
                        out_err   <= p2_err;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: drives mac_seq_ctrl with a behavioural 16-lane MAC
// and compares each result with dot products computed in plain arithmetic.
module tb_mac_seq_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_last;
    logic [127:0] in_a, in_b;
    logic         mac_reset;
    logic [127:0] mac_a, mac_b;
    logic [19:0]  mac_out;
    logic         out_valid, out_ready;
    logic [23:0]  out_data;
    logic [4:0]   out_cnt;
    logic         out_err, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_seq_ctrl dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_a(in_a), .in_b(in_b),
        .mac_reset(mac_reset), .mac_a(mac_a), .mac_b(mac_b),
        .mac_out(mac_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cnt(out_cnt), .out_err(out_err),
        .busy(busy)
    );

    function automatic longint ref_dot(input logic [127:0] a,
                                       input logic [127:0] b);
        longint s = 0;
        for (int i = 0; i < 16; i++)
            s += longint'($signed(a[8*i +: 8])) * longint'($signed(b[8*i +: 8]));
        return s;
    endfunction

    function automatic logic [127:0] fill(input logic [7:0] v);
        return {16{v}};
    endfunction

    // MAC environment: samples on its load edge, publishes on the add edge
    logic [127:0] ra, rb;
    logic         madd;
    always @(posedge clk) begin
        if (mac_reset) begin
            madd    <= 1'b0;
            mac_out <= '0;
        end else if (!madd) begin
            ra   <= mac_a;
            rb   <= mac_b;
            madd <= 1'b1;
        end else begin
            mac_out <= 20'(ref_dot(ra, rb));
            madd    <= 1'b0;
        end
    end

    task automatic push(input logic [127:0] a, input logic [127:0] b,
                        input logic last);
        int t = 0;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input int hold, output logic [23:0] d,
                           output logic [4:0] c, output logic e);
        int t = 0;
        while (!out_valid && t < 200) begin
            @(posedge clk); #1; t++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_timeout out_valid=%b required 1", out_valid);
        end
        d = out_data; c = out_cnt; e = out_err;
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({in_ready, out_valid, out_err, busy, mac_reset} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_flags got %b required 00001",
                     {in_ready, out_valid, out_err, busy, mac_reset});
        end
        checks++;
        if (out_data !== 24'd0 || out_cnt !== 5'd0) begin
            errors++;
            $display("FAIL reset_data got %0h/%0d required 0/0", out_data, out_cnt);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mac_reset !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release mac_reset=%b in_ready=%b required 0 1",
                     mac_reset, in_ready);
        end
    endtask

    task automatic test_single;
        logic [2:0] v;
        push(fill(8'd1), fill(8'd1), 1'b1);
        v[0] = out_valid;
        @(posedge clk); #1; v[1] = out_valid;
        @(posedge clk); #1; v[2] = out_valid;
        checks++;
        if (v !== 3'b100) begin
            errors++;
            $display("FAIL single_latency got %b required 100", v);
        end
        checks++;
        if (out_data !== 24'd16 || out_cnt !== 5'd1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL single_result got %0d/%0d/%b required 16/1/0",
                     out_data, out_cnt, out_err);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_handshake valid=%b busy=%b required 0 0",
                     out_valid, busy);
        end
    endtask

    task automatic test_two_neg;
        logic [23:0] d; logic [4:0] c; logic e;
        logic [23:0] want;
        want = 24'(-64);
        push(fill(8'hFF), fill(8'd2), 1'b0);
        push(fill(8'hFF), fill(8'd2), 1'b1);
        collect(0, d, c, e);
        checks++;
        if (d !== want || c !== 5'd2 || e !== 1'b0) begin
            errors++;
            $display("FAIL two_neg got %0h/%0d/%b required %0h/2/0", d, c, e, want);
        end
    endtask

    task automatic test_full16;
        logic [23:0] d; logic [4:0] c; logic e;
        int hi = 0;
        for (int i = 0; i < 16; i++) begin
            push(fill(8'h80), fill(8'h80), i == 15);
            if (in_ready !== 1'b0) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL full16_ready_odd got %0d required 0", hi);
        end
        collect(0, d, c, e);
        checks++;
        if (d !== 24'd4194304 || c !== 5'd16 || e !== 1'b0) begin
            errors++;
            $display("FAIL full16 got %0d/%0d/%b required 4194304/16/0", d, c, e);
        end
    endtask

    task automatic test_backpressure;
        logic [23:0] d; logic [4:0] c; logic e;
        logic [23:0] held;
        int bad = 0;
        int t = 0;
        push(fill(8'd3), fill(8'hFF), 1'b1);
        while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
        held = out_data;
        in_a = fill(8'd5); in_b = fill(8'd7); in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0 || held !== 24'(-48)) begin
            errors++;
            $display("FAIL backpressure bad=%0d data=%0h required 0 %0h",
                     bad, held, 24'(-48));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        push(fill(8'd5), fill(8'd7), 1'b1);
        collect(0, d, c, e);
        checks++;
        if (d !== 24'd560 || c !== 5'd1) begin
            errors++;
            $display("FAIL bp_next got %0d/%0d required 560/1", d, c);
        end
    endtask

    task automatic test_truncate;
        logic [23:0] d; logic [4:0] c; logic e;
        for (int i = 0; i < 16; i++)
            push(fill(8'd1), fill(8'd1), 1'b0);
        collect(2, d, c, e);
        checks++;
        if (d !== 24'd256 || c !== 5'd16 || e !== 1'b1) begin
            errors++;
            $display("FAIL truncate got %0d/%0d/%b required 256/16/1", d, c, e);
        end
        push(fill(8'd1), fill(8'd1), 1'b1);
        collect(0, d, c, e);
        checks++;
        if (d !== 24'd16 || c !== 5'd1 || e !== 1'b0) begin
            errors++;
            $display("FAIL trunc_next got %0d/%0d/%b required 16/1/0", d, c, e);
        end
    endtask

    task automatic test_random;
        logic [23:0] d; logic [4:0] c; logic e;
        logic [127:0] a, b;
        longint total;
        logic [23:0] want;
        int n;
        for (int v = 0; v < 20; v++) begin
            n = $urandom_range(1, 16);
            total = 0;
            for (int k = 0; k < n; k++) begin
                a = {$urandom, $urandom, $urandom, $urandom};
                b = {$urandom, $urandom, $urandom, $urandom};
                total += ref_dot(a, b);
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                push(a, b, k == n - 1);
            end
            want = 24'(total);
            collect($urandom_range(0, 3), d, c, e);
            checks++;
            if (d !== want || c !== 5'(n) || e !== 1'b0) begin
                errors++;
                $display("FAIL random_vec%0d got %0h/%0d/%b required %0h/%0d/0",
                         v, d, c, e, want, n);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [23:0] d; logic [4:0] c; logic e;
        int seen = 0;
        push(fill(8'd1), fill(8'd1), 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, mac_reset, busy, in_ready} !== 4'b0100) begin
            errors++;
            $display("FAIL midreset_flags got %b required 0100",
                     {out_valid, mac_reset, busy, in_ready});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        checks++;
        if (mac_reset !== 1'b1) begin
            errors++;
            $display("FAIL midreset_hold mac_reset=%b required 1", mac_reset);
        end
        @(posedge clk); #1;
        checks++;
        if (mac_reset !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release mac_reset=%b required 0", mac_reset);
        end
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_discard got %0d required 0", seen);
        end
        push(fill(8'd2), fill(8'd3), 1'b1);
        collect(0, d, c, e);
        checks++;
        if (d !== 24'd96 || c !== 5'd1 || e !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next got %0d/%0d/%b required 96/1/0", d, c, e);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_two_neg;
        test_full16;
        test_backpressure;
        test_truncate;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
